// File: rtl/fround_pipe.sv
// fround_pipe: two-stage pipelined round-to-integral unit for IEEE-754 binary formats.
//
// Each accepted operation carries its own rounding mode (FLOOR, CEIL, TRUNC, or RNE with
// ties-to-even) and an opaque tag. The result stays a float of the same format. The
// inexact flag is set when the result differs numerically from the operand.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   reset      asynchronous, active-high; clears both stages and the outputs
//   in_valid   op/mode/tag are valid this cycle
//   in_ready   the unit accepts an op this cycle
//   op         operand {sign, exp, fra}
//   mode       00 FLOOR, 01 CEIL, 10 TRUNC, 11 RNE
//   tag        returned unchanged on out_tag
//   out_valid  result/out_tag/inexact are valid
//   out_ready  the consumer accepts the result
//   result     rounded value, same format as op
//   out_tag    tag of this result
//   inexact    1 when result != op numerically (NaN/Inf report 0)
//
// Handshake: a transfer happens on a rising edge where valid & ready are both 1, on both
// the input and output sides. The pipe uses one global stall. adv = ~out_valid | out_ready,
// and in_ready = adv. When adv is 0, every register holds, so result/out_tag/inexact stay
// stable while out_valid & ~out_ready. A stage with valid=0 moves forward as a bubble.
module fround_pipe #(
    parameter int EXP_W = 8,
    parameter int FRA_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+FRA_W:0] op,
    input  logic [1:0]           mode,
    input  logic [TAG_W-1:0]     tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+FRA_W:0] result,
    output logic [TAG_W-1:0]     out_tag,
    output logic                 inexact
);

    localparam int W    = 1 + EXP_W + FRA_W;
    localparam int BIAS = (1 << (EXP_W - 1)) - 1;

    localparam logic [1:0] MODE_FLOOR = 2'b00;
    localparam logic [1:0] MODE_CEIL  = 2'b01;
    localparam logic [1:0] MODE_TRUNC = 2'b10;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;
    localparam logic [EXP_W-1:0] EXP_BIAS = EXP_W'(BIAS);
    localparam logic [EXP_W-1:0] EXP_HALF = EXP_W'(BIAS - 1);
    // Smallest biased exponent whose value is always integral (e >= FRA_W).
    localparam logic [EXP_W:0]   EXP_INT  = (EXP_W + 1)'(BIAS + FRA_W);
    localparam logic [FRA_W-1:0] FRA_ONE  = FRA_W'(1);
    localparam logic [FRA_W:0]   MANT_ONE = (FRA_W + 1)'(1);

    // ---------------------------------------------------------------- flow control
    logic adv;
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // ---------------------------------------------------------------- stage 1 (comb)
    logic             in_sign;
    logic [EXP_W-1:0] in_exp;
    logic [FRA_W-1:0] in_fra;
    assign in_sign = op[W-1];
    assign in_exp  = op[W-2:FRA_W];
    assign in_fra  = op[FRA_W-1:0];

    logic is_special, is_zero, is_int, is_small;
    assign is_special = (in_exp == EXP_ONES);
    assign is_zero    = (in_exp == '0) && (in_fra == '0);
    assign is_int     = ({1'b0, in_exp} >= EXP_INT);
    assign is_small   = (in_exp < EXP_BIAS);

    // shamt = number of dropped fraction bits (FRA_W - e). It only matters when
    // 0 <= e < FRA_W, where it is in 1..FRA_W.
    logic [EXP_W:0]   shamt;
    logic [FRA_W-1:0] drop_m;
    logic [FRA_W-1:0] g_m;
    logic [FRA_W:0]   tval;
    logic [FRA_W:0]   unit;
    logic             any_frac, g_bit, st_bit, lsb_bit;

    assign shamt    = EXP_INT - {1'b0, in_exp};
    // Mask of dropped bits. It wraps to all-ones when shamt == FRA_W.
    assign drop_m   = (FRA_ONE << shamt) - FRA_ONE;
    assign g_m      = drop_m ^ (drop_m >> 1);   // top dropped bit only
    assign any_frac = |(in_fra & drop_m);
    assign g_bit    = |(in_fra & g_m);
    assign st_bit   = |(in_fra & (drop_m >> 1));
    assign tval     = {1'b1, in_fra & ~drop_m};
    assign unit     = MANT_ONE << shamt;        // one ULP of the integer part
    assign lsb_bit  = |(tval & unit);

    logic         s1_d_norm, s1_d_inc, s1_d_inexact;
    logic [W-1:0] s1_d_res;

    always_comb begin
        s1_d_norm    = 1'b0;
        s1_d_inc     = 1'b0;
        s1_d_inexact = 1'b0;
        s1_d_res     = op;
        if (is_special || is_zero || is_int) begin
            s1_d_res = op;
        end else if (is_small) begin
            // |x| < 1: the answer is a signed 0 or a signed 1.0.
            s1_d_inexact = 1'b1;
            case (mode)
                MODE_FLOOR: s1_d_res = in_sign  ? {in_sign, EXP_BIAS, {FRA_W{1'b0}}} : {in_sign, {(W-1){1'b0}}};
                MODE_CEIL:  s1_d_res = !in_sign ? {in_sign, EXP_BIAS, {FRA_W{1'b0}}} : {in_sign, {(W-1){1'b0}}};
                MODE_TRUNC: s1_d_res = {in_sign, {(W-1){1'b0}}};
                default:    s1_d_res = (in_exp == EXP_HALF && in_fra != '0)
                                       ? {in_sign, EXP_BIAS, {FRA_W{1'b0}}}
                                       : {in_sign, {(W-1){1'b0}}};
            endcase
        end else begin
            s1_d_norm    = 1'b1;
            s1_d_inexact = any_frac;
            case (mode)
                MODE_FLOOR: s1_d_inc = in_sign & any_frac;
                MODE_CEIL:  s1_d_inc = ~in_sign & any_frac;
                MODE_TRUNC: s1_d_inc = 1'b0;
                default:    s1_d_inc = g_bit & (st_bit | lsb_bit);
            endcase
        end
    end

    // ---------------------------------------------------------------- stage 1 regs
    logic             s1_valid, s1_norm, s1_inc, s1_inexact;
    logic [W-1:0]     s1_res;      // final result, or the original op when s1_norm
    logic [FRA_W:0]   s1_tval, s1_unit;
    logic [TAG_W-1:0] s1_tag;

    // ---------------------------------------------------------------- stage 2 (comb)
    // T always has its hidden bit set. After adding one integer ULP, the sum either keeps
    // that bit or wraps to zero. A clear hidden bit therefore means a carry into the exponent.
    // In that case the wrapped fraction bits are already zero.
    logic [FRA_W:0]   sum;
    logic             carry;
    logic [EXP_W-1:0] exp_n;
    logic [W-1:0]     res2;

    assign sum   = s1_tval + (s1_inc ? s1_unit : '0);
    assign carry = ~sum[FRA_W];
    assign exp_n = s1_res[W-2:FRA_W] + {{(EXP_W-1){1'b0}}, carry};
    assign res2  = s1_norm ? {s1_res[W-1], exp_n, sum[FRA_W-1:0]} : s1_res;

    // ---------------------------------------------------------------- registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid   <= 1'b0;
            s1_norm    <= 1'b0;
            s1_inc     <= 1'b0;
            s1_inexact <= 1'b0;
            s1_res     <= '0;
            s1_tval    <= '0;
            s1_unit    <= '0;
            s1_tag     <= '0;
            out_valid  <= 1'b0;
            result     <= '0;
            out_tag    <= '0;
            inexact    <= 1'b0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            out_valid <= s1_valid;
            if (in_valid) begin
                s1_norm    <= s1_d_norm;
                s1_inc     <= s1_d_inc;
                s1_inexact <= s1_d_inexact;
                s1_res     <= s1_d_res;
                s1_tval    <= tval;
                s1_unit    <= unit;
                s1_tag     <= tag;
            end
            if (s1_valid) begin
                result  <= res2;
                out_tag <= s1_tag;
                inexact <= s1_inexact;
            end
        end
    end

endmodule

// File: tb/tb_fround_pipe.sv
// Testbench for fround_pipe. It uses directed vectors, a streaming test, a backpressure
// test, a reset test with ops in flight, and a random phase. A queue-based scoreboard
// checks every output.
module tb_fround_pipe;
  localparam int EXP_W = 8;
  localparam int FRA_W = 23;
  localparam int TAG_W = 4;
  localparam int W     = 1 + EXP_W + FRA_W;
  localparam int BIAS  = (1 << (EXP_W - 1)) - 1;
  localparam int EW    = TAG_W + 1 + W;

  // ---------------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic             in_valid, in_ready, out_valid, out_ready, inexact;
  logic [W-1:0]     op, result;
  logic [1:0]       mode;
  logic [TAG_W-1:0] tag, out_tag;

  fround_pipe #(.EXP_W(EXP_W), .FRA_W(FRA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .mode(mode), .tag(tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .out_tag(out_tag), .inexact(inexact)
  );

  int errors = 0;
  int checks = 0;
  logic [EW-1:0] exp_q[$];
  int acc_cyc[16];
  int pop_cyc[16];
  logic rand_done;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] expv);
    checks++;
    assert (got === expv) else begin
      errors++;
      $error("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  // ---------------------------------------------------------------- reference model
  // Returns {inexact, result}. The model works on the integer value instead of
  // fraction masks: it splits the value into n (the integer part) and rem (the
  // dropped bits), rounds n, then normalises n back to a float.
  function automatic logic [W:0] ref_round(input logic [W-1:0] x, input logic [1:0] m);
    logic             s, up;
    logic [EXP_W-1:0] ex;
    logic [FRA_W-1:0] fr;
    longint           mant, n, rem, half;
    int               e, d, p;
    s  = x[W-1];
    ex = x[W-2:FRA_W];
    fr = x[FRA_W-1:0];
    if (ex == '1 || (ex == '0 && fr == '0) || int'(ex) >= BIAS + FRA_W) return {1'b0, x};
    if (int'(ex) < BIAS) begin
      case (m)
        2'b00:   up = s;
        2'b01:   up = !s;
        2'b10:   up = 1'b0;
        default: up = (int'(ex) == BIAS - 1) && (fr != '0);
      endcase
      return {1'b1, s, up ? EXP_W'(BIAS) : EXP_W'(0), FRA_W'(0)};
    end
    e    = int'(ex) - BIAS;
    d    = FRA_W - e;
    mant = (longint'(1) << FRA_W) | longint'(fr);
    n    = mant >> d;
    rem  = mant - (n << d);
    half = longint'(1) << (d - 1);
    case (m)
      2'b00:   up = s && (rem != 0);
      2'b01:   up = !s && (rem != 0);
      2'b10:   up = 1'b0;
      default: up = (rem > half) || (rem == half && (n % 2) == 1);
    endcase
    if (up) n = n + 1;
    p = 0;
    for (int i = 0; i < 62; i++) if ((n >> i) != 0) p = i;
    return {rem != 0, s, EXP_W'(BIAS + p), FRA_W'((n - (longint'(1) << p)) << (FRA_W - p))};
  endfunction

  function automatic logic [W-1:0] rand_op();
    int               k;
    logic [EXP_W-1:0] ex;
    logic [FRA_W-1:0] fr;
    k  = $urandom_range(0, 9);
    fr = FRA_W'($urandom());
    if (k == 0)      ex = '1;
    else if (k == 1) ex = '0;
    else             ex = EXP_W'($urandom_range(BIAS - 3, BIAS + FRA_W + 2));
    if (k == 2) fr = '0;
    return {1'($urandom_range(0, 1)), ex, fr};
  endfunction

  // ---------------------------------------------------------------- driver tasks
  // Offers one op and waits until it is accepted. Leaves in_valid high so that
  // consecutive calls stream back to back. exp_r is the expected {inexact, result}.
  task automatic send_exp(input logic [W-1:0] o, input logic [1:0] m,
                          input logic [TAG_W-1:0] t, input logic [W:0] exp_r);
    int guard;
    guard    = 0;
    in_valid = 1'b1;
    op       = o;
    mode     = m;
    tag      = t;
    @(negedge clk);
    while (in_ready !== 1'b1 && guard < 50) begin
      guard++;
      @(negedge clk);
    end
    checks++;
    assert (in_ready === 1'b1) else begin
      errors++;
      $error("FAIL accept_timeout tag=%0d in_ready=%b exp=1", t, in_ready);
    end
    if (in_ready === 1'b1) begin
      exp_q.push_back({t, exp_r});
      acc_cyc[int'(t)] = cyc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [W-1:0] o, input logic [1:0] m, input logic [TAG_W-1:0] t);
    send_exp(o, m, t, ref_round(o, m));
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard;
    guard    = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk);
      guard++;
    end
    #1;
    check("drain_queue_empty", 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------------------------------------------------------- scoreboard
  // While the output is stalled, the held output is compared against the head
  // entry on every cycle. The entry is popped only on an actual transfer.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_output result=%h tag=%0d exp=none", result, out_tag);
      end
      if (exp_q.size() != 0) begin
        checks++;
        assert ({out_tag, inexact, result} === exp_q[0]) else begin
          errors++;
          $error("FAIL out_data got tag=%0d inx=%b res=%h exp tag=%0d inx=%b res=%h",
                 out_tag, inexact, result,
                 exp_q[0][EW-1:W+1], exp_q[0][W], exp_q[0][W-1:0]);
        end
        if (out_ready === 1'b1) begin
          pop_cyc[int'(out_tag)] = cyc;
          void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------------------------------------------------------- directed vectors
  localparam int ND = 21;
  logic [W-1:0] d_op  [ND] = '{32'hC0200000, 32'hBFE00000, 32'h3FA00000, 32'hBE99999A,
                               32'hBFE00000, 32'h40200000, 32'h40600000, 32'h3F000000,
                               32'h4B000001, 32'h4B000001, 32'h7FC00000, 32'hFF800000,
                               32'h80000000, 32'h80000000, 32'h3F000001, 32'h80000001,
                               32'h00000001, 32'h3F800000, 32'h4AFFFFFF, 32'h3FC00000,
                               32'hBE99999A};
  logic [1:0]   d_md  [ND] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd3, 2'd3, 2'd3,
                               2'd0, 2'd3, 2'd1, 2'd2, 2'd3, 2'd0, 2'd3, 2'd0,
                               2'd1, 2'd0, 2'd3, 2'd3, 2'd2};
  logic [W-1:0] d_res [ND] = '{32'hC0400000, 32'hC0000000, 32'h40000000, 32'h80000000,
                               32'hBF800000, 32'h40000000, 32'h40800000, 32'h00000000,
                               32'h4B000001, 32'h4B000001, 32'h7FC00000, 32'hFF800000,
                               32'h80000000, 32'h80000000, 32'h3F800000, 32'hBF800000,
                               32'h3F800000, 32'h3F800000, 32'h4B000000, 32'h40000000,
                               32'h80000000};
  logic         d_inx [ND] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                               1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  // ---------------------------------------------------------------- sequence
  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    op        = '0;
    mode      = 2'b00;
    tag       = '0;
    out_ready = 1'b1;
    rand_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_result",    64'(result),    64'd0);
    check("reset_out_tag",   64'(out_tag),   64'd0);
    check("reset_inexact",   64'(inexact),   64'd0);
    check("reset_in_ready",  64'(in_ready),  64'd1);
    reset = 1'b0;
    idle(2);

    // Directed vectors, streamed back to back.
    for (int i = 0; i < ND; i++) send_exp(d_op[i], d_md[i], TAG_W'(i % 16), {d_inx[i], d_res[i]});
    drain();

    // Stream of 8 ops with out_ready held high: each result appears 2 cycles after
    // its accept, and the results come out in order with no gaps.
    for (int i = 0; i < 8; i++) send(rand_op(), 2'($urandom_range(0, 3)), TAG_W'(i));
    drain();
    check("stream_accept_b2b", 64'(acc_cyc[7] - acc_cyc[0]), 64'd7);
    for (int i = 0; i < 8; i++) check("stream_out_cycle", 64'(pop_cyc[i] - acc_cyc[0]), 64'(2 + i));

    // Backpressure in the middle of a stream.
    fork
      begin
        for (int i = 0; i < 8; i++) send(rand_op(), 2'($urandom_range(0, 3)), TAG_W'(8 + i));
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          check("stall_in_ready",  64'(in_ready),  64'd0);
          check("stall_out_valid", 64'(out_valid), 64'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two ops in flight.
    send(32'h40200000, 2'd3, 4'd1);
    send(32'hC0200000, 2'd0, 4'd2);
    in_valid = 1'b0;
    check("inflight_out_valid", 64'(out_valid), 64'd1);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_result",    64'(result),    64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle(6);
    check("post_reset_no_stale", 64'(out_valid), 64'd0);

    // Random ops with random backpressure and idle gaps.
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          send(rand_op(), 2'($urandom_range(0, 3)), TAG_W'($urandom_range(0, 15)));
          if ($urandom_range(0, 3) == 0) idle(1);
        end
        in_valid  = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog_timeout time=%0t limit=200000", $time);
    $fatal(1, "watchdog");
  end

endmodule
